// File: rtl/alu_sequencer_pkg.sv
// Types and opcode field positions shared by the ALU and its control sequencer.
package alu_sequencer_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_MUL = 3'd5,
      ALU_SR  = 3'd6,
      ALU_SL  = 3'd7
   } alu_operation_t;

   typedef enum logic {
      ALU_RX        = 1'b0,
      ALU_IMMEDIATE = 1'b1
   } alu_operand_t;

   typedef enum logic [1:0] {
      S_OPCODE = 2'd0,
      S_IMM    = 2'd1,
      S_EXEC   = 2'd2
   } alu_seq_state_t;

   localparam int OP_MSB      = 7;
   localparam int OP_LSB      = 5;
   localparam int OPERAND_BIT = 4;
   localparam int RX_MSB      = 3;
   localparam int RX_LSB      = 2;

   // Reserved bits [1:0] must be zero unless the build tolerates them.
   function automatic logic opcode_reserved_violation(input logic [7:0] op_byte,
                                                      input bit allow_reserved);
      return !allow_reserved && (op_byte[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU control sequencer: decodes opcode/immediate bytes from fetch,
// drives registered ALU selects and pulses r0_we/retire when the result commits.
//
// state    | meaning
// S_OPCODE | waiting for an opcode byte
// S_IMM    | opcode accepted, waiting for its immediate byte
// S_EXEC   | ALU selects stable; stall countdown, r0_we on the final cycle
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int unsigned EXEC_STALL_CYCLES = 0,
   parameter bit          ALLOW_RESERVED    = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           instr_valid,
   output logic           instr_ready,
   input  logic [7:0]     instr_byte,
   output alu_operation_t alu_operation,
   output alu_operand_t   alu_operand,
   output logic [7:0]     immediate,
   output logic [1:0]     rx_sel,
   output logic           r0_we,
   output logic           retire,
   output logic           illegal
);

   localparam logic [3:0] STALL_LOAD = 4'(EXEC_STALL_CYCLES);

   alu_seq_state_t state_q, state_d;
   alu_operation_t alu_operation_q, alu_operation_d;
   alu_operand_t   alu_operand_q, alu_operand_d;
   logic [7:0]     immediate_q, immediate_d;
   logic [1:0]     rx_sel_q, rx_sel_d;
   logic [3:0]     stall_cnt_q, stall_cnt_d;
   logic           r0_we_q, r0_we_d;
   logic           retire_q, retire_d;
   logic           illegal_q, illegal_d;
   logic           xfer;
   logic           enter_exec;

   assign instr_ready = (state_q != S_EXEC);
   assign xfer        = instr_valid && instr_ready;

   always_comb begin
      state_d         = state_q;
      alu_operation_d = alu_operation_q;
      alu_operand_d   = alu_operand_q;
      immediate_d     = immediate_q;
      rx_sel_d        = rx_sel_q;
      stall_cnt_d     = stall_cnt_q;
      r0_we_d         = 1'b0;
      illegal_d       = 1'b0;
      enter_exec      = 1'b0;

      case (state_q)
         S_OPCODE: begin
            if (xfer) begin
               if (opcode_reserved_violation(instr_byte, ALLOW_RESERVED)) begin
                  illegal_d = 1'b1;
               end else begin
                  alu_operation_d = alu_operation_t'(instr_byte[OP_MSB:OP_LSB]);
                  alu_operand_d   = alu_operand_t'(instr_byte[OPERAND_BIT]);
                  rx_sel_d        = instr_byte[RX_MSB:RX_LSB];
                  if (instr_byte[OPERAND_BIT]) begin
                     state_d = S_IMM;
                  end else begin
                     enter_exec = 1'b1;
                  end
               end
            end
         end
         S_IMM: begin
            if (xfer) begin
               immediate_d = instr_byte;
               enter_exec  = 1'b1;
            end
         end
         S_EXEC: begin
            // r0_we is registered, so it is raised on the edge where the count reaches 0
            if (stall_cnt_q == 4'd0) begin
               state_d = S_OPCODE;
            end else begin
               stall_cnt_d = stall_cnt_q - 4'd1;
               r0_we_d     = (stall_cnt_q == 4'd1);
            end
         end
         default: begin
            state_d = S_OPCODE;
         end
      endcase

      if (enter_exec) begin
         state_d     = S_EXEC;
         stall_cnt_d = STALL_LOAD;
         r0_we_d     = (STALL_LOAD == 4'd0);
      end

      retire_d = r0_we_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_OPCODE;
         alu_operation_q <= ALU_ADD;
         alu_operand_q   <= ALU_RX;
         immediate_q     <= 8'h00;
         rx_sel_q        <= 2'd0;
         stall_cnt_q     <= 4'd0;
         r0_we_q         <= 1'b0;
         retire_q        <= 1'b0;
         illegal_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         alu_operation_q <= alu_operation_d;
         alu_operand_q   <= alu_operand_d;
         immediate_q     <= immediate_d;
         rx_sel_q        <= rx_sel_d;
         stall_cnt_q     <= stall_cnt_d;
         r0_we_q         <= r0_we_d;
         retire_q        <= retire_d;
         illegal_q       <= illegal_d;
      end
   end

   assign alu_operation = alu_operation_q;
   assign alu_operand   = alu_operand_q;
   assign immediate     = immediate_q;
   assign rx_sel        = rx_sel_q;
   assign r0_we         = r0_we_q;
   assign retire        = retire_q;
   assign illegal       = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: schedule-based reference model on a zero-stall strict
// instance, plus directed checks on a 3-stall reserved-tolerant instance.
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   localparam int N_A     = 0;
   localparam bit ALLOW_A = 1'b0;
   localparam int N_B     = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic           valid_a = 1'b0, ready_a, we_a, ret_a, ill_a;
   logic [7:0]     byte_a = 8'h00, imm_a;
   logic [1:0]     rx_a;
   alu_operation_t op_a;
   alu_operand_t   opd_a;

   logic           valid_b = 1'b0, ready_b, we_b, ret_b, ill_b;
   logic [7:0]     byte_b = 8'h00, imm_b;
   logic [1:0]     rx_b;
   alu_operation_t op_b;
   alu_operand_t   opd_b;

   alu_sequencer #(.EXEC_STALL_CYCLES(N_A), .ALLOW_RESERVED(ALLOW_A)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .instr_valid(valid_a), .instr_ready(ready_a),
      .instr_byte(byte_a), .alu_operation(op_a), .alu_operand(opd_a),
      .immediate(imm_a), .rx_sel(rx_a), .r0_we(we_a), .retire(ret_a), .illegal(ill_a)
   );

   alu_sequencer #(.EXEC_STALL_CYCLES(N_B), .ALLOW_RESERVED(1'b1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .instr_valid(valid_b), .instr_ready(ready_b),
      .instr_byte(byte_b), .alu_operation(op_b), .alu_operand(opd_b),
      .immediate(imm_b), .rx_sel(rx_b), .r0_we(we_b), .retire(ret_b), .illegal(ill_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model for instance A: cycle k = number of rising edges since reset release.
   // Each accepted instruction books an execution window [busy_lo, busy_hi] ending in r0_we.
   int         cyc = 0;
   int         we_at = -1, ill_at = -1, busy_lo = 1, busy_hi = 0;
   bit         pend_imm = 1'b0;
   logic [2:0] m_op = 3'd0;
   logic       m_opd = 1'b0;
   logic [7:0] m_imm = 8'h00;
   logic [1:0] m_rx = 2'd0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic bit m_ready(input int k);
      return !(k >= busy_lo && k <= busy_hi);
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         we_at = -1; ill_at = -1; busy_lo = 1; busy_hi = 0; pend_imm = 1'b0;
         m_op = 3'd0; m_opd = 1'b0; m_imm = 8'h00; m_rx = 2'd0;
      end
      chk("model_ready",    32'(ready_a), 32'(m_ready(cyc)));
      chk("model_r0_we",    32'(we_a),    32'(cyc == we_at));
      chk("model_retire",   32'(ret_a),   32'(cyc == we_at));
      chk("model_illegal",  32'(ill_a),   32'(cyc == ill_at));
      chk("model_op",       32'(op_a),    32'(m_op));
      chk("model_operand",  32'(opd_a),   32'(m_opd));
      chk("model_imm",      32'(imm_a),   32'(m_imm));
      chk("model_rx",       32'(rx_a),    32'(m_rx));
      if (rst_n && valid_a && m_ready(cyc)) begin
         if (pend_imm) begin
            m_imm    = byte_a;
            pend_imm = 1'b0;
            busy_lo  = cyc + 1;
            busy_hi  = cyc + 1 + N_A;
            we_at    = busy_hi;
         end else if (!ALLOW_A && byte_a[1:0] != 2'b00) begin
            ill_at = cyc + 1;
         end else begin
            m_op  = byte_a[7:5];
            m_opd = byte_a[4];
            m_rx  = byte_a[3:2];
            if (byte_a[4]) begin
               pend_imm = 1'b1;
            end else begin
               busy_lo = cyc + 1;
               busy_hi = cyc + 1 + N_A;
               we_at   = busy_hi;
            end
         end
      end
   end

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the edge that transferred b.
   task automatic send_a(input logic [7:0] b);
      int n = 0;
      valid_a = 1'b1;
      byte_a  = b;
      @(negedge clk);
      while (!ready_a && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!ready_a) chk("send_a_timeout", 32'(ready_a), 32'd1);
      @(posedge clk);
      #1;
      valid_a = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b);
      int n = 0;
      valid_b = 1'b1;
      byte_b  = b;
      @(negedge clk);
      while (!ready_b && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!ready_b) chk("send_b_timeout", 32'(ready_b), 32'd1);
      @(posedge clk);
      #1;
      valid_b = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rb;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ADD r2
      send_a(8'h08);
      @(negedge clk);
      chk("add_r0_we",   32'(we_a),    32'd1);
      chk("add_retire",  32'(ret_a),   32'd1);
      chk("add_ready",   32'(ready_a), 32'd0);
      chk("add_rx",      32'(rx_a),    32'd2);
      chk("add_op",      32'(op_a),    32'd0);
      chk("add_operand", 32'(opd_a),   32'd0);
      @(negedge clk);
      chk("add_we_drop",  32'(we_a),    32'd0);
      chk("add_ready_up", 32'(ready_a), 32'd1);

      // SUB #5
      to_drive();
      send_a(8'h30);
      send_a(8'h05);
      @(negedge clk);
      chk("subi_we",      32'(we_a),  32'd1);
      chk("subi_imm",     32'(imm_a), 32'h05);
      chk("subi_op",      32'(op_a),  32'd1);
      chk("subi_operand", 32'(opd_a), 32'd1);

      // SUB # with a gap before the immediate
      to_drive();
      send_a(8'h30);
      repeat (4) begin
         @(negedge clk);
         chk("imm_wait_we",    32'(we_a),    32'd0);
         chk("imm_wait_ready", 32'(ready_a), 32'd1);
      end
      to_drive();
      send_a(8'h7F);
      @(negedge clk);
      chk("imm_gap_imm", 32'(imm_a), 32'h7F);
      chk("imm_gap_we",  32'(we_a),  32'd1);

      // reserved bits set, then XOR r1
      to_drive();
      send_a(8'h01);
      @(negedge clk);
      chk("ill_pulse", 32'(ill_a), 32'd1);
      chk("ill_we",    32'(we_a),  32'd0);
      chk("ill_op",    32'(op_a),  32'd1);
      chk("ill_rx",    32'(rx_a),  32'd0);
      to_drive();
      send_a(8'h84);
      @(negedge clk);
      chk("xor_we",  32'(we_a),  32'd1);
      chk("xor_rx",  32'(rx_a),  32'd1);
      chk("xor_op",  32'(op_a),  32'd4);
      chk("xor_ill", 32'(ill_a), 32'd0);

      // reset while waiting for an immediate
      to_drive();
      send_a(8'h30);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_imm_op",    32'(op_a),    32'd0);
      chk("rst_imm_imm",   32'(imm_a),   32'd0);
      chk("rst_imm_we",    32'(we_a),    32'd0);
      chk("rst_imm_ready", 32'(ready_a), 32'd1);
      to_drive();
      rst_n = 1'b1;
      send_a(8'h08);
      @(negedge clk);
      chk("post_rst_we", 32'(we_a), 32'd1);
      chk("post_rst_rx", 32'(rx_a), 32'd2);

      // randomized traffic on instance A, checked every cycle by the model
      repeat (400) begin
         @(posedge clk);
         #1;
         valid_a = ($urandom_range(9) < 7);
         rb = 8'($urandom);
         if ($urandom_range(3) != 0) rb[1:0] = 2'b00;
         byte_a = rb;
      end
      @(posedge clk);
      #1;
      valid_a = 1'b0;
      repeat (3) @(negedge clk);

      // instance B: MUL #2 with three stall cycles
      to_drive();
      send_b(8'hB0);
      send_b(8'h02);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mul_ready", 32'(ready_b), 32'd0);
         chk("mul_we",    32'(we_b),    32'(i == 3));
         chk("mul_op",    32'(op_b),    32'd5);
         chk("mul_imm",   32'(imm_b),   32'h02);
      end
      @(negedge clk);
      chk("mul_ready_up", 32'(ready_b), 32'd1);
      chk("mul_we_drop",  32'(we_b),    32'd0);

      // reserved bits tolerated on B: executes as ADD r0
      to_drive();
      send_b(8'h01);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rsv_ok_ill", 32'(ill_b), 32'd0);
         chk("rsv_ok_we",  32'(we_b),  32'(i == 3));
         chk("rsv_ok_op",  32'(op_b),  32'd0);
         chk("rsv_ok_rx",  32'(rx_b),  32'd0);
      end

      // reset during EXEC before r0_we
      to_drive();
      send_b(8'h30);
      send_b(8'h05);
      repeat (2) begin
         @(negedge clk);
         chk("exec_rst_pre_we", 32'(we_b), 32'd0);
      end
      to_drive();
      rst_n = 1'b0;
      @(negedge clk);
      chk("exec_rst_op",      32'(op_b),    32'd0);
      chk("exec_rst_operand", 32'(opd_b),   32'd0);
      chk("exec_rst_imm",     32'(imm_b),   32'd0);
      chk("exec_rst_rx",      32'(rx_b),    32'd0);
      chk("exec_rst_ready",   32'(ready_b), 32'd1);
      chk("exec_rst_retire",  32'(ret_b),   32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("exec_rst_no_we", 32'(we_b), 32'd0);
      end
      to_drive();
      rst_n = 1'b1;
      send_b(8'h08);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("exec_rst_next_we", 32'(we_b), 32'(i == 3));
      end
      chk("exec_rst_next_rx", 32'(rx_b), 32'd2);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
